// File: rtl/motor_cmd_scheduler_if.sv
// Purpose : bundles the requester, e-stop and motor-status signals of motor_cmd_scheduler.
// Latency : n/a (wires only).
// Backpressure: none; requesters hold their valid level, and ownership is reported through the grants.
// Ports   : req_a/req_a_valid, req_b/req_b_valid, estop (towards scheduler);
//           cmd, grant_a, grant_b, busy, fault, state_o (from scheduler).
interface motor_cmd_scheduler_if;
    logic [1:0] req_a;
    logic       req_a_valid;
    logic [1:0] req_b;
    logic       req_b_valid;
    logic       estop;
    logic [1:0] cmd;
    logic       grant_a;
    logic       grant_b;
    logic       busy;
    logic       fault;
    logic [1:0] state_o;

    // Requester / system side.
    modport master (
        output req_a, req_a_valid, req_b, req_b_valid, estop,
        input  cmd, grant_a, grant_b, busy, fault, state_o
    );

    // Scheduler side.
    modport slave (
        input  req_a, req_a_valid, req_b, req_b_valid, estop,
        output cmd, grant_a, grant_b, busy, fault, state_o
    );
endinterface

// File: rtl/motor_cmd_scheduler.sv
// Purpose : arbitrates the 2-bit motor command between panel A (priority) and auto B, with reversal dead-time and e-stop.
// Latency : requests are sampled on prescaled ticks; cmd updates on the tick edge, and e-stop forces cmd=00 on the next clock edge.
// Backpressure: a requester owns the motor while its grant is high; unsafe changes are delayed through DRAIN.
// Ports   : orgclk, rst (sync, active high); bus = motor_cmd_scheduler_if.slave
//           (req_a/req_b + valids, estop in; cmd, grant_a, grant_b, busy, fault, state_o out).
module motor_cmd_scheduler #(
    parameter int PRESCALE   = 4,
    parameter int DEAD_TICKS = 3
) (
    input  logic                        orgclk,
    input  logic                        rst,
    motor_cmd_scheduler_if.slave        bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_ESTOP = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q;
    logic          tick;
    logic [1:0]    cmd_q, cmd_d;
    logic [1:0]    target_q, target_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;

    // Owner as seen on this tick, after A has had the chance to preempt B.
    logic          own_a, own_b, own_vld;
    logic [1:0]    r;

    // Changes between opposing motions, or leaving brake for a motion, must pass through 00.
    function automatic logic needs_drain(input logic [1:0] from, input logic [1:0] to);
        return (from != 2'b00) && (to != 2'b00) && (to != 2'b11) && (to != from);
    endfunction

    assign tick = (pcnt_q == PW'(PRESCALE - 1));

    always_comb begin
        own_a   = gnt_a_q | (gnt_b_q & bus.req_a_valid);
        own_b   = gnt_b_q & ~bus.req_a_valid;
        own_vld = own_a ? bus.req_a_valid : (own_b ? bus.req_b_valid : 1'b0);
        r       = own_a ? bus.req_a : bus.req_b;
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        target_d = target_q;
        dcnt_d   = dcnt_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        fault_d  = fault_q;

        if (bus.estop) begin
            state_d = S_ESTOP;
            cmd_d   = 2'b00;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            fault_d = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_a_valid) begin
                        gnt_a_d = 1'b1;
                        cmd_d   = bus.req_a;
                        state_d = S_RUN;
                    end else if (bus.req_b_valid) begin
                        gnt_b_d = 1'b1;
                        cmd_d   = bus.req_b;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    gnt_a_d = own_a;
                    gnt_b_d = own_b;
                    if (!own_vld) begin
                        // Owner released: a moving motor still gets the full dead-time.
                        gnt_a_d = 1'b0;
                        gnt_b_d = 1'b0;
                        cmd_d   = 2'b00;
                        if (cmd_q == 2'b00) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_DRAIN;
                            target_d = 2'b00;
                            dcnt_d   = DW'(DEAD_TICKS);
                        end
                    end else if (r != cmd_q) begin
                        if (needs_drain(cmd_q, r)) begin
                            state_d  = S_DRAIN;
                            cmd_d    = 2'b00;
                            target_d = r;
                            dcnt_d   = DW'(DEAD_TICKS);
                        end else begin
                            cmd_d = r;
                        end
                    end
                end
                S_DRAIN: begin
                    // An owner that lets go during DRAIN loses the grant; the drain then ends in IDLE.
                    gnt_a_d  = own_a & own_vld;
                    gnt_b_d  = own_b & own_vld;
                    target_d = own_vld ? r : 2'b00;
                    if (dcnt_q == DW'(1)) begin
                        dcnt_d = '0;
                        if (own_vld) begin
                            cmd_d   = r;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                S_ESTOP: begin
                    state_d  = S_DRAIN;
                    target_d = 2'b00;
                    dcnt_d   = DW'(DEAD_TICKS);
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_IDLE) begin
            fault_d = 1'b0;
        end
        busy_d = (state_d == S_DRAIN);
    end

    always_ff @(posedge orgclk) begin
        if (rst) begin
            pcnt_q   <= '0;
            state_q  <= S_IDLE;
            cmd_q    <= 2'b00;
            target_q <= 2'b00;
            dcnt_q   <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pcnt_q   <= tick ? '0 : pcnt_q + 1'b1;
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            target_q <= target_d;
            dcnt_q   <= dcnt_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.grant_a = gnt_a_q;
    assign bus.grant_b = gnt_b_q;
    assign bus.busy    = busy_q;
    assign bus.fault   = fault_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Purpose : randomized and directed stimulus for motor_cmd_scheduler, checked cycle by cycle against a reference model.
// Latency : the model predicts the outputs after every clock edge; the monitor compares them 1 ns after that edge.
// Backpressure: none; the stimulus drives requester levels directly.
module tb_motor_cmd_scheduler;
    localparam int PRESCALE   = 4;
    localparam int DEAD_TICKS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_ESTOP = 3;

    logic orgclk = 1'b0;
    logic rst;

    motor_cmd_scheduler_if bus();

    motor_cmd_scheduler #(
        .PRESCALE   (PRESCALE),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .orgclk (orgclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 orgclk = ~orgclk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected {cmd, grant_a, grant_b, busy, fault, state} after each edge.
    logic [7:0] exp_q[$];

    // Reference model state.
    int         m_edges;
    int         m_mode;
    int         m_owner;     // 0 none, 1 A, 2 B
    logic [1:0] m_cmd;
    logic [1:0] m_target;
    int         m_left;      // dead ticks still to be spent at 00
    bit         m_fault;

    function automatic bit is_motion(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    // Going to a motion from any other non-stop command must pass through the dead time.
    function automatic bit reversal(input logic [1:0] from, input logic [1:0] to);
        return is_motion(to) && (from != 2'b00) && (from != to);
    endfunction

    task automatic start_drain(input logic [1:0] tgt);
        m_mode   = M_DRAIN;
        m_cmd    = 2'b00;
        m_target = tgt;
        m_left   = DEAD_TICKS;
    endtask

    // Predict the DUT outputs after the coming rising edge, given the inputs driven now.
    task automatic model_edge();
        bit         tick;
        bit         rv;
        logic [1:0] r;
        if (rst) begin
            m_edges  = 0;
            m_mode   = M_IDLE;
            m_owner  = 0;
            m_cmd    = 2'b00;
            m_target = 2'b00;
            m_left   = 0;
            m_fault  = 1'b0;
        end else begin
            tick = ((m_edges % PRESCALE) == PRESCALE - 1);
            m_edges++;
            if (bus.estop) begin
                m_mode  = M_ESTOP;
                m_cmd   = 2'b00;
                m_owner = 0;
                m_fault = 1'b1;
            end else if (tick) begin
                if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_owner == 2 && bus.req_a_valid)
                    m_owner = 1;
                r  = (m_owner == 1) ? bus.req_a : bus.req_b;
                rv = (m_owner == 1) ? bus.req_a_valid : ((m_owner == 2) ? bus.req_b_valid : 1'b0);
                case (m_mode)
                    M_ESTOP: begin
                        m_mode   = M_DRAIN;
                        m_left   = DEAD_TICKS;
                        m_target = 2'b00;
                    end
                    M_IDLE: begin
                        if (bus.req_a_valid) begin
                            m_owner = 1; m_cmd = bus.req_a; m_mode = M_RUN;
                        end else if (bus.req_b_valid) begin
                            m_owner = 2; m_cmd = bus.req_b; m_mode = M_RUN;
                        end
                    end
                    M_RUN: begin
                        if (!rv) begin
                            m_owner = 0;
                            if (m_cmd == 2'b00) m_mode = M_IDLE;
                            else start_drain(2'b00);
                        end else if (r != m_cmd) begin
                            if (reversal(m_cmd, r)) start_drain(r);
                            else m_cmd = r;
                        end
                    end
                    default: begin
                        if (!rv) m_owner = 0;
                        m_target = rv ? r : 2'b00;
                        m_left--;
                        if (m_left == 0) begin
                            if (m_owner != 0) begin
                                m_cmd  = m_target;
                                m_mode = M_RUN;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                endcase
                if (m_mode == M_IDLE) m_fault = 1'b0;
            end
        end
        exp_q.push_back({m_cmd, m_owner == 1, m_owner == 2, m_mode == M_DRAIN, m_fault, 2'(m_mode)});
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(negedge orgclk);
        end
    endtask

    // Monitor: compares every edge that has a prediction queued.
    logic [7:0] mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge orgclk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {bus.cmd, bus.grant_a, bus.grant_b, bus.busy, bus.fault, bus.state_o};
                vectors++;
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got cmd=%b ga=%b gb=%b busy=%b fault=%b st=%b, want cmd=%b ga=%b gb=%b busy=%b fault=%b st=%b",
                             $time, mon_act[7:6], mon_act[5], mon_act[4], mon_act[3], mon_act[2], mon_act[1:0],
                             mon_exp[7:6], mon_exp[5], mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1:0]);
                end
                if (bus.grant_a && bus.grant_b) begin
                    miscompares++;
                    $display("FAIL grant_exclusive t=%0t got grant_a=1 grant_b=1, want at most one", $time);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.req_a       = 2'b00;
        bus.req_a_valid = 1'b0;
        bus.req_b       = 2'b00;
        bus.req_b_valid = 1'b0;
        bus.estop       = 1'b0;
        @(negedge orgclk);
        cyc(2);

        // A requests forward out of reset: granted on the 4th edge.
        rst = 1'b0; bus.req_a = 2'b01; bus.req_a_valid = 1'b1;
        cyc(6);
        // Reversal through DRAIN.
        bus.req_a = 2'b10;
        cyc(20);

        // B owns forward, then A preempts with reverse.
        rst = 1'b1; bus.req_a_valid = 1'b0;
        cyc(1);
        rst = 1'b0; bus.req_b = 2'b01; bus.req_b_valid = 1'b1;
        cyc(8);
        bus.req_a = 2'b10; bus.req_a_valid = 1'b1;
        cyc(20);

        // Single-cycle e-stop pulse, then recovery through DRAIN to IDLE.
        cyc(1);
        bus.estop = 1'b1;
        cyc(1);
        bus.estop = 1'b0;
        cyc(24);

        // Brake is safe, leaving brake for motion drains, stop is immediate.
        bus.req_a = 2'b01;
        cyc(20);
        bus.req_a = 2'b11;
        cyc(6);
        bus.req_a = 2'b01;
        cyc(16);
        bus.req_a = 2'b00;
        cyc(6);

        // Reset in the middle of a DRAIN.
        bus.req_a = 2'b10;
        cyc(4);
        bus.req_a = 2'b01;
        cyc(6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(8);

        // Randomized traffic, with inputs changing on tick and non-tick cycles alike.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)   bus.req_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)   bus.req_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)  bus.req_a_valid = ~bus.req_a_valid;
            if ($urandom_range(0, 11) == 0)  bus.req_b_valid = ~bus.req_b_valid;
            if (bus.estop) bus.estop = ($urandom_range(0, 3) != 0);
            else           bus.estop = ($urandom_range(0, 119) == 0);
            rst = ($urandom_range(0, 599) == 0);
            cyc(1);
        end

        @(posedge orgclk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue got %0d unchecked predictions, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/motor_cmd_scheduler.md
Name: motor_cmd_scheduler

Overview:
Sequences and arbitrates the 2-bit motor command bus between two requesters: A (manual panel, high priority) and B (auto controller). Enforces a stop dead-time before any direction reversal and provides an emergency-stop override. Its cmd output drives the motor command input directly. Decisions are taken on an internal prescaled tick; e-stop acts on every clock.

Parameters:
PRESCALE, 4, orgclk cycles per decision tick (>=2)
DEAD_TICKS, 3, ticks cmd is held at 00 before a reversal is applied (>=1)

Ports:
orgclk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
req_a  input  2  requester A command (00 stop, 01 fwd, 10 rev, 11 brake)
req_a_valid  input  1  A requests ownership
req_b  input  2  requester B command
req_b_valid  input  1  B requests ownership
estop  input  1  emergency stop, level-sensitive
cmd  output  2  registered motor command
grant_a  output  1  A owns the motor
grant_b  output  1  B owns the motor
busy  output  1  high while in DRAIN
fault  output  1  high from e-stop entry until return to IDLE
state_o  output  2  IDLE=00, RUN=01, DRAIN=10, ESTOP=11

Behaviour:
- Reset: cmd=00, grant_a=grant_b=0, busy=0, fault=0, state=IDLE, prescaler=0, dead counter=0, target=00.
- Prescaler counts 0..PRESCALE-1 and wraps. tick=(pcnt==PRESCALE-1). First tick is the PRESCALE-th edge after rst deasserts. The prescaler runs freely, including through ESTOP.
- All outputs are registered. Every non-estop state change happens on the edge of a tick cycle. r = req of the current owner.
- Safe transitions apply immediately: 00->any, any->00, any->11.
- Unsafe transitions go through DRAIN: 01<->10, 11->01, 11->10. On entry: cmd<=00, target<=r, dcnt<=DEAD_TICKS.
- IDLE (no owner):
  - On tick: if req_a_valid, owner A; else if req_b_valid, owner B; else stay.
  - On grant: cmd<=r and go to RUN. r=00 is allowed.
- RUN:
  - On tick, owner valid low: drop grant. If cmd==00 go to IDLE; else go to DRAIN with target 00 and no owner.
  - On tick, owner B and req_a_valid: A preempts on the same edge (grant_b<=0, grant_a<=1). The new r=req_a is then applied by the transition rules.
  - On tick, r==cmd: hold. r!=cmd: apply a safe transition immediately, or enter DRAIN for an unsafe one.
- DRAIN:
  - cmd=00, busy=1. Decrement dcnt on each tick.
  - Preemption of B by A is allowed during DRAIN. target is re-sampled from r each tick.
  - On the tick where dcnt==1: if an owner exists, cmd<=target and go to RUN; otherwise cmd stays 00 and go to IDLE.
  - DRAIN therefore holds cmd=00 for exactly DEAD_TICKS ticks.
- ESTOP:
  - Entry: estop=1 on any cycle (tick or not, any state). Next edge: cmd<=00, grants<=0, fault<=1, busy<=0, state ESTOP.
  - Hold while estop=1.
  - Exit: first tick with estop=0 goes to DRAIN with no owner and dcnt=DEAD_TICKS, then to IDLE. fault clears on the IDLE entry edge.
- Priority on the same edge: rst > estop > tick logic.
- Simultaneous req_a_valid and req_b_valid in IDLE: A wins. B is granted only when A is not valid at a tick.
- grant_a and grant_b are never both high. cmd never goes 01<->10 without >=DEAD_TICKS ticks at 00.
- Request changes between ticks are ignored. Only values present on tick cycles are sampled.

Test Plan:
1. PRESCALE=4. Release rst; req_a=01, req_a_valid=1. At edge 4: cmd=01, grant_a=1, state_o=01. Edges 1-3: cmd=00.
2. From 1, req_a 01->10. Next tick: cmd=00, busy=1, state_o=10. Exactly 12 cycles later: cmd=10, busy=0.
3. B owns with req_b=01, cmd=01. A asserts req_a=10. At tick: grant_b=0, grant_a=1, cmd=00. After 3 ticks: cmd=10.
4. RUN with cmd=01; pulse estop high on a non-tick cycle. Next edge: cmd=00, fault=1, grants=0, state_o=11. Drop estop. Next tick: DRAIN. 3 ticks later: IDLE, fault=0.
5. A at cmd=01 requests 11. Next tick: cmd=11, no DRAIN. Then request 01: cmd=00 for 3 ticks, then 01. Then request 00: immediate cmd=00, stay RUN.
6. Assert rst mid-DRAIN. Next edge: all outputs at reset values, pcnt=0. The first tick falls 4 edges after rst deasserts.
